// File: rtl/phy_rx_pkg.sv
// Shared definitions for the phy_rx receive path.
//   PHY_BW  : default data width of the interleaved stream and of each lane
//   slot_t  : one-bit slot index within a two-cycle round
//   SLOT_L0 : slot carrying the lane0 byte
//   SLOT_L1 : slot carrying the lane1 byte
package phy_rx_pkg;

    localparam int PHY_BW = 8;

    typedef logic slot_t;

    localparam slot_t SLOT_L0 = 1'b0;
    localparam slot_t SLOT_L1 = 1'b1;

endpackage : phy_rx_pkg

// File: rtl/demux1x2.sv
// demux1x2 : 1:2 lane de-interleaver for the phy_rx path.
// Splits a byte stream that alternates lane0/lane1 every clock back into two
// lanes and presents both bytes of a round together, one round per 2 cycles.
//
// Ports
//   clk           in   1   clock, rising edge
//   reset         in   1   asynchronous reset, active low
//   Entrada       in   BW  interleaved stream byte
//   validEntrada  in   1   Entrada holds a valid byte this cycle
//   sync          in   1   force the current cycle to be slot 0 (lane0)
//   Salida0       out  BW  lane0 byte of the last completed round
//   Salida1       out  BW  lane1 byte of the last completed round
//   validSalida0  out  1   one-cycle strobe, Salida0 carries a valid byte
//   validSalida1  out  1   one-cycle strobe, Salida1 carries a valid byte
//   pair_valid    out  1   one-cycle strobe, both lanes valid this round
//   sync_drop     out  1   one-cycle strobe, sync discarded a pending lane0 byte
module demux1x2
    import phy_rx_pkg::*;
#(
    parameter int BW = PHY_BW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BW-1:0] Entrada,
    input  logic          validEntrada,
    input  logic          sync,
    output logic [BW-1:0] Salida0,
    output logic [BW-1:0] Salida1,
    output logic          validSalida0,
    output logic          validSalida1,
    output logic          pair_valid,
    output logic          sync_drop
);

    slot_t          phase_q,   phase_d;
    logic [BW-1:0]  hold0_q,   hold0_d;
    logic           hold0_v_q, hold0_v_d;
    logic [BW-1:0]  salida0_q, salida0_d;
    logic [BW-1:0]  salida1_q, salida1_d;
    logic           vsal0_q,   vsal0_d;
    logic           vsal1_q,   vsal1_d;
    logic           pair_q,    pair_d;
    logic           drop_q,    drop_d;

    // sync overrides the running phase and pins this cycle to lane0.
    slot_t slot;
    assign slot = sync ? SLOT_L0 : phase_q;

    always_comb begin
        phase_d   = ~slot;
        hold0_d   = hold0_q;
        hold0_v_d = hold0_v_q;
        salida0_d = salida0_q;
        salida1_d = salida1_q;
        vsal0_d   = 1'b0;
        vsal1_d   = 1'b0;
        pair_d    = 1'b0;
        drop_d    = 1'b0;

        if (slot == SLOT_L0) begin
            // Capture the lane0 byte; invalid bytes are stored as zero so a
            // stale value can never leak out with the next round.
            hold0_d   = validEntrada ? Entrada : '0;
            hold0_v_d = validEntrada;
            // A re-alignment that lands where lane1 was expected throws away
            // the lane0 byte already waiting for its partner.
            drop_d    = sync && (phase_q == SLOT_L1) && hold0_v_q;
        end else begin
            salida0_d = hold0_q;
            vsal0_d   = hold0_v_q;
            salida1_d = validEntrada ? Entrada : '0;
            vsal1_d   = validEntrada;
            pair_d    = hold0_v_q & validEntrada;
            hold0_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q   <= SLOT_L0;
            hold0_q   <= '0;
            hold0_v_q <= 1'b0;
            salida0_q <= '0;
            salida1_q <= '0;
            vsal0_q   <= 1'b0;
            vsal1_q   <= 1'b0;
            pair_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            hold0_q   <= hold0_d;
            hold0_v_q <= hold0_v_d;
            salida0_q <= salida0_d;
            salida1_q <= salida1_d;
            vsal0_q   <= vsal0_d;
            vsal1_q   <= vsal1_d;
            pair_q    <= pair_d;
            drop_q    <= drop_d;
        end
    end

    assign Salida0      = salida0_q;
    assign Salida1      = salida1_q;
    assign validSalida0 = vsal0_q;
    assign validSalida1 = vsal1_q;
    assign pair_valid   = pair_q;
    assign sync_drop    = drop_q;

endmodule : demux1x2

// File: tb/tb_demux1x2.sv
// Self-checking bench for demux1x2. Output vector order:
// {Salida0, Salida1, validSalida0, validSalida1, pair_valid, sync_drop}
module tb_demux1x2;

    localparam int BW = 8;
    localparam int OW = 2 * BW + 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [BW-1:0] Entrada = '0;
    logic          validEntrada = 1'b0;
    logic          sync = 1'b0;
    logic [BW-1:0] Salida0, Salida1;
    logic          validSalida0, validSalida1, pair_valid, sync_drop;

    int total = 0;
    int bad   = 0;

    demux1x2 #(.BW(BW)) dut (
        .clk          (clk),
        .reset        (reset),
        .Entrada      (Entrada),
        .validEntrada (validEntrada),
        .sync         (sync),
        .Salida0      (Salida0),
        .Salida1      (Salida1),
        .validSalida0 (validSalida0),
        .validSalida1 (validSalida1),
        .pair_valid   (pair_valid),
        .sync_drop    (sync_drop)
    );

    always #5 clk = ~clk;

    wire [OW-1:0] obs = {Salida0, Salida1, validSalida0, validSalida1, pair_valid, sync_drop};

    // Apply one stream byte for one clock; returns at the following falling
    // edge so outputs are sampled away from the active edge.
    task automatic drive(input logic v, input logic [BW-1:0] d, input logic s);
        validEntrada = v;
        Entrada      = d;
        sync         = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at a falling edge with reset released, so the next
    // rising edge is the first slot-0 cycle.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        validEntrada = 1'b0;
        Entrada = '0;
        sync = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [OW-1:0] exp;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            validEntrada = 1'b1;
            Entrada = 8'($urandom);
            sync = 1'($urandom);
            @(negedge clk);
            exp = '0;
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, exp);
            end
        end
        reset = 1'b1;
        drive(1'b0, 8'($urandom), 1'b0);
        exp = '0;
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", obs, exp);
        end
        $display("test_reset: outputs after release %h", obs);
    endtask

    task automatic test_stream();
        logic [BW-1:0] a0, b0, a1, b1;
        logic [OW-1:0] exp;
        a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
        do_reset();
        drive(1'b1, a0, 1'b0);
        exp = '0;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stream_c1 got=%h want=%h", obs, exp); end
        drive(1'b1, b0, 1'b0);
        exp = {a0, b0, 4'b1110};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stream_c2 got=%h want=%h", obs, exp); end
        drive(1'b1, a1, 1'b0);
        exp = {a0, b0, 4'b0000};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stream_c3 got=%h want=%h", obs, exp); end
        drive(1'b1, b1, 1'b0);
        exp = {a1, b1, 4'b1110};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stream_c4 got=%h want=%h", obs, exp); end
        drive(1'b0, 8'($urandom), 1'b0);
        exp = {a1, b1, 4'b0000};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL stream_c5 got=%h want=%h", obs, exp); end
        $display("test_stream: rounds %h/%h %h/%h", a0, b0, a1, b1);
    endtask

    task automatic test_lane_invalid();
        logic [BW-1:0] a, b;
        logic [OW-1:0] exp;
        a = 8'($urandom); b = 8'($urandom);
        do_reset();
        drive(1'b1, a, 1'b0);
        drive(1'b0, 8'($urandom), 1'b0);
        exp = {a, 8'h00, 4'b1000};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL lane1_invalid got=%h want=%h", obs, exp); end
        drive(1'b0, 8'($urandom), 1'b0);
        drive(1'b1, b, 1'b0);
        exp = {8'h00, b, 4'b0100};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL lane0_invalid got=%h want=%h", obs, exp); end
        $display("test_lane_invalid: lane0-only %h, lane1-only %h", a, b);
    endtask

    task automatic test_sync_slot1();
        logic [BW-1:0] x, y, a, b, c, d, e;
        logic [OW-1:0] exp;
        x = 8'($urandom); y = 8'($urandom); a = 8'($urandom); b = 8'($urandom);
        c = 8'($urandom); d = 8'($urandom); e = 8'($urandom);
        do_reset();
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b1, x, 1'b1);
        exp = {8'h00, 8'h00, 4'b0001};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_drop got=%h want=%h", obs, exp); end
        drive(1'b1, y, 1'b0);
        exp = {x, y, 4'b1110};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_realign got=%h want=%h", obs, exp); end
        // sync held high: every cycle re-captures lane0, nothing is emitted
        drive(1'b1, a, 1'b1);
        exp = {x, y, 4'b0000};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_hold0 got=%h want=%h", obs, exp); end
        drive(1'b1, b, 1'b1);
        exp = {x, y, 4'b0001};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_hold1 got=%h want=%h", obs, exp); end
        drive(1'b0, c, 1'b1);
        exp = {x, y, 4'b0001};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_hold2 got=%h want=%h", obs, exp); end
        drive(1'b1, d, 1'b1);
        exp = {x, y, 4'b0000};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_hold3 got=%h want=%h", obs, exp); end
        drive(1'b1, e, 1'b0);
        exp = {d, e, 4'b1110};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_hold_exit got=%h want=%h", obs, exp); end
        $display("test_sync_slot1: dropped a5, realigned %h/%h, held exit %h/%h", x, y, d, e);
    endtask

    task automatic test_sync_slot0();
        logic [BW-1:0] a, b;
        logic [OW-1:0] exp;
        a = 8'($urandom); b = 8'($urandom);
        do_reset();
        drive(1'b1, a, 1'b1);
        exp = '0;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_slot0_c1 got=%h want=%h", obs, exp); end
        drive(1'b1, b, 1'b0);
        exp = {a, b, 4'b1110};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL sync_slot0_c2 got=%h want=%h", obs, exp); end
        $display("test_sync_slot0: round %h/%h", a, b);
    endtask

    task automatic test_reset_midround();
        logic [BW-1:0] a, b, b2;
        logic [OW-1:0] exp;
        a = 8'($urandom) | 8'h01; b = 8'($urandom) | 8'h01; b2 = 8'($urandom);
        do_reset();
        drive(1'b1, a, 1'b0);
        drive(1'b1, b, 1'b0);
        drive(1'b1, 8'h3C, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        exp = '0;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL async_reset got=%h want=%h", obs, exp); end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 8'($urandom), 1'b0);
        exp = '0;
        total++;
        if (obs !== exp) begin bad++; $display("FAIL midround_release got=%h want=%h", obs, exp); end
        drive(1'b1, b2, 1'b0);
        exp = {8'h00, b2, 4'b0100};
        total++;
        if (obs !== exp) begin bad++; $display("FAIL midround_lost got=%h want=%h", obs, exp); end
        $display("test_reset_midround: pending 3c discarded, lane1 %h", b2);
    endtask

    // Loopback against an ideal 2:1 interleaver: each lane's valid bytes must
    // come out in order, and each round's outputs follow the round's inputs.
    task automatic test_loopback();
        logic [BW-1:0] q0[$];
        logic [BW-1:0] q1[$];
        logic [BW-1:0] d0, d1, s0, s1, want;
        logic          v0, v1;
        logic [OW-1:0] exp;
        s0 = '0; s1 = '0;
        do_reset();
        for (int r = 0; r < 1000; r++) begin
            v0 = 1'($urandom); v1 = 1'($urandom);
            d0 = 8'($urandom); d1 = 8'($urandom);
            if (v0) q0.push_back(d0);
            if (v1) q1.push_back(d1);
            drive(v0, d0, 1'b0);
            exp = {s0, s1, 4'b0000};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL loop_slot0 r=%0d got=%h want=%h", r, obs, exp); end
            drive(v1, d1, 1'b0);
            s0 = v0 ? d0 : '0;
            s1 = v1 ? d1 : '0;
            exp = {s0, s1, v0, v1, v0 & v1, 1'b0};
            total++;
            if (obs !== exp) begin bad++; $display("FAIL loop_slot1 r=%0d got=%h want=%h", r, obs, exp); end
            if (validSalida0) begin
                want = (q0.size() > 0) ? q0.pop_front() : 'x;
                total++;
                if (Salida0 !== want) begin bad++; $display("FAIL loop_lane0 r=%0d got=%h want=%h", r, Salida0, want); end
            end
            if (validSalida1) begin
                want = (q1.size() > 0) ? q1.pop_front() : 'x;
                total++;
                if (Salida1 !== want) begin bad++; $display("FAIL loop_lane1 r=%0d got=%h want=%h", r, Salida1, want); end
            end
            $display("round %0d: in %b:%h %b:%h out %h", r, v0, d0, v1, d1, obs);
        end
        total++;
        if (q0.size() + q1.size() != 0) begin
            bad++;
            $display("FAIL loop_leftover got=%0d want=0", q0.size() + q1.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_lane_invalid();
        test_sync_slot1();
        test_sync_slot0();
        test_reset_midround();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux1x2
